// File: rtl/tanh_dispatch.sv
// tanh_dispatch: vector-level initiator for the fixed-latency tanh unit.
// Accepts a whole Q8.8 vector, streams one element per cycle into the
// activation unit, tracks in-flight elements with a tag shift register and
// reassembles the returned results by index before presenting them downstream.
// Optional feature macro: TANH_DISPATCH_PERF_EN adds saturating vec_count and
// stall_count performance counters.
module tanh_dispatch #(
  parameter int DATA_W   = 16,
  parameter int VEC_LEN  = 8,
  parameter int PIPE_LAT = 5,
  parameter int IDX_W    = $clog2(VEC_LEN)
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [VEC_LEN*DATA_W-1:0] in_vec,
  output logic [DATA_W-1:0]         act_data_out,
  input  logic [DATA_W-1:0]         act_data_in,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [VEC_LEN*DATA_W-1:0] out_vec,
`ifdef TANH_DISPATCH_PERF_EN
  output logic [31:0]               vec_count,
  output logic [31:0]               stall_count,
`endif
  output logic                      busy
);

  localparam int CNT_W = IDX_W + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(VEC_LEN - 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(VEC_LEN - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   issueIdx_q, issueIdx_d;
  logic [CNT_W-1:0]   collectCnt_q, collectCnt_d;
  logic [DATA_W-1:0]  inBuf_q  [VEC_LEN];
  logic [DATA_W-1:0]  result_q [VEC_LEN];
  logic               tagValid_q [PIPE_LAT];
  logic [IDX_W-1:0]   tagIdx_q   [PIPE_LAT];

  logic accept;
  logic issue;
  logic capture;
  logic handshake;

  // Next-state, handshake outputs and the element presented to the unit
  always_comb begin
    state_d      = state_q;
    issueIdx_d   = issueIdx_q;
    collectCnt_d = collectCnt_q;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    act_data_out = '0;
    accept       = (state_q == IDLE) && in_valid;
    issue        = (state_q == ISSUE);
    capture      = ((state_q == ISSUE) || (state_q == DRAIN)) && tagValid_q[PIPE_LAT-1];
    handshake    = (state_q == DONE) && out_ready;

    if (capture) begin
      collectCnt_d = collectCnt_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          issueIdx_d   = '0;
          collectCnt_d = '0;
          state_d      = ISSUE;
        end
      end
      ISSUE: begin
        act_data_out = inBuf_q[issueIdx_q];
        if (issueIdx_q == LAST_IDX) begin
          state_d = (capture && (collectCnt_q == LAST_CNT)) ? DONE : DRAIN;
        end else begin
          issueIdx_d = issueIdx_q + 1'b1;
        end
      end
      DRAIN: begin
        if (capture && (collectCnt_q == LAST_CNT)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q != IDLE);

  // FSM state, issue index and collection counter registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      issueIdx_q   <= '0;
      collectCnt_q <= '0;
    end else begin
      state_q      <= state_d;
      issueIdx_q   <= issueIdx_d;
      collectCnt_q <= collectCnt_d;
    end
  end

  // Tag pipe mirrors the unit latency so each returning result carries its index
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < PIPE_LAT; i++) begin
        tagValid_q[i] <= 1'b0;
        tagIdx_q[i]   <= '0;
      end
    end else begin
      tagValid_q[0] <= issue;
      tagIdx_q[0]   <= issueIdx_q;
      for (int i = 1; i < PIPE_LAT; i++) begin
        tagValid_q[i] <= tagValid_q[i-1];
        tagIdx_q[i]   <= tagIdx_q[i-1];
      end
    end
  end

  // Input buffer latched on acceptance; results written back by returned tag index
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int k = 0; k < VEC_LEN; k++) begin
        inBuf_q[k]  <= '0;
        result_q[k] <= '0;
      end
    end else begin
      if (accept) begin
        for (int k = 0; k < VEC_LEN; k++) begin
          inBuf_q[k] <= in_vec[k*DATA_W +: DATA_W];
        end
      end
      if (capture) begin
        result_q[tagIdx_q[PIPE_LAT-1]] <= act_data_in;
      end
    end
  end

  for (genvar g = 0; g < VEC_LEN; g++) begin : g_outPack
    assign out_vec[g*DATA_W +: DATA_W] = result_q[g];
  end

`ifdef TANH_DISPATCH_PERF_EN
  // Saturating counts of completed vectors and downstream-stalled DONE cycles
  always_ff @(posedge clock) begin
    if (reset) begin
      vec_count   <= '0;
      stall_count <= '0;
    end else begin
      if (handshake && (vec_count != 32'hFFFFFFFF)) begin
        vec_count <= vec_count + 32'd1;
      end
      if ((state_q == DONE) && !out_ready && (stall_count != 32'hFFFFFFFF)) begin
        stall_count <= stall_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_tanh_dispatch.sv
// tb_tanh_dispatch: self-checking bench for tanh_dispatch.
// A default instance (VEC_LEN=8, PIPE_LAT=5) is checked every cycle against a
// transaction-level model; a small instance (VEC_LEN=2, PIPE_LAT=1) is checked
// with directed literals. The activation unit is modelled as data+1 delayed.
module tb_tanh_dispatch;

  localparam int DW     = 16;
  localparam int VL     = 8;
  localparam int PL     = 5;
  localparam int DONE_T = VL + PL + 1;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  // Default-size instance signals
  logic           inValid  = 1'b0;
  logic           outReady = 1'b0;
  logic [VL*DW-1:0] inVec  = '0;
  logic           inReady, outValid, busy;
  logic [DW-1:0]  actOut, actIn;
  logic [VL*DW-1:0] outVec;

  // Small instance signals
  logic           sInValid  = 1'b0;
  logic           sOutReady = 1'b0;
  logic [2*DW-1:0] sInVec   = '0;
  logic           sInReady, sOutValid, sBusy;
  logic [DW-1:0]  sActOut;
  logic [DW-1:0]  sActIn = '0;
  logic [2*DW-1:0] sOutVec;

`ifdef TANH_DISPATCH_PERF_EN
  logic [31:0] vecCount, stallCount, sVecCount, sStallCount;
`endif

  int  checks = 0;
  int  errors = 0;
  bit  cmpEn  = 1'b0;

  tanh_dispatch #(.DATA_W(DW), .VEC_LEN(VL), .PIPE_LAT(PL)) dut (
    .clock        (clock),
    .reset        (reset),
    .in_valid     (inValid),
    .in_ready     (inReady),
    .in_vec       (inVec),
    .act_data_out (actOut),
    .act_data_in  (actIn),
    .out_valid    (outValid),
    .out_ready    (outReady),
    .out_vec      (outVec),
`ifdef TANH_DISPATCH_PERF_EN
    .vec_count    (vecCount),
    .stall_count  (stallCount),
`endif
    .busy         (busy)
  );

  tanh_dispatch #(.DATA_W(DW), .VEC_LEN(2), .PIPE_LAT(1)) dutSmall (
    .clock        (clock),
    .reset        (reset),
    .in_valid     (sInValid),
    .in_ready     (sInReady),
    .in_vec       (sInVec),
    .act_data_out (sActOut),
    .act_data_in  (sActIn),
    .out_valid    (sOutValid),
    .out_ready    (sOutReady),
    .out_vec      (sOutVec),
`ifdef TANH_DISPATCH_PERF_EN
    .vec_count    (sVecCount),
    .stall_count  (sStallCount),
`endif
    .busy         (sBusy)
  );

  // Activation unit models: result = operand + 1, fixed latency, never stalls
  logic [DW-1:0] actPipe [PL];
  initial for (int i = 0; i < PL; i++) actPipe[i] = '0;
  always @(posedge clock) begin
    actPipe[0] <= actOut + 16'd1;
    for (int i = 1; i < PL; i++) actPipe[i] <= actPipe[i-1];
  end
  assign actIn = actPipe[PL-1];

  always @(posedge clock) sActIn <= sActOut + 16'd1;

  // Transaction model: mT is the cycle number since acceptance (1 = first cycle after)
  logic [DW-1:0] mIn [VL];
  bit            mActive = 1'b0;
  int            mT      = 0;
  always @(posedge clock) begin
    if (reset) begin
      mActive <= 1'b0;
      mT      <= 0;
    end else if (!mActive) begin
      if (inValid) begin
        mActive <= 1'b1;
        mT      <= 1;
        for (int k = 0; k < VL; k++) mIn[k] <= inVec[k*DW +: DW];
      end
    end else if (mT >= DONE_T && outReady) begin
      mActive <= 1'b0;
      mT      <= 0;
    end else begin
      mT <= mT + 1;
    end
  end

  function automatic logic [DW-1:0] expAct();
    if (mActive && mT >= 1 && mT <= VL) return mIn[mT-1];
    return '0;
  endfunction

  function automatic logic [VL*DW-1:0] expVec();
    logic [VL*DW-1:0] v;
    for (int k = 0; k < VL; k++) v[k*DW +: DW] = mIn[k] + 16'd1;
    return v;
  endfunction

  task automatic checkVal(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Every-cycle comparison of the default instance against the model
  always @(negedge clock) begin
    if (cmpEn) begin
      checkVal("cyc act_data_out", actOut, expAct());
      checkVal("cyc busy", busy, mActive);
      checkVal("cyc in_ready", inReady, !mActive);
      checkVal("cyc out_valid", outValid, mActive && mT >= DONE_T);
      if (mActive && mT >= DONE_T) checkVal("cyc out_vec", outVec, expVec());
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic waitValid(input string name);
    int n = 0;
    while (outValid !== 1'b1 && n < 60) begin
      step();
      n++;
    end
    checkVal(name, outValid, 1'b1);
  endtask

  task automatic waitIdle(input string name);
    int n = 0;
    while (inReady !== 1'b1 && n < 60) begin
      step();
      n++;
    end
    checkVal(name, inReady, 1'b1);
  endtask

  task automatic applyStimulus();
    int lat;
    // reset state
    reset = 1'b1;
    repeat (3) step();
    checkVal("rst in_ready", inReady, 1'b1);
    checkVal("rst out_valid", outValid, 1'b0);
    checkVal("rst busy", busy, 1'b0);
    checkVal("rst act_data_out", actOut, 16'h0000);
    checkVal("rst out_vec", outVec, 128'h0);
    reset = 1'b0;
    cmpEn = 1'b1;

    // basic vector, latency 14, then 10 stalled DONE cycles
    inVec   = 128'h0800_0700_0600_0500_0400_0300_0200_0100;
    inValid = 1'b1;
    step();
    inValid = 1'b0;
    checkVal("t1 first issue", actOut, 16'h0100);
    lat = 1;
    while (outValid !== 1'b1 && lat < 40) begin
      step();
      lat++;
    end
    checkVal("t1 latency", lat, 14);
    checkVal("t1 out_vec", outVec, 128'h0801_0701_0601_0501_0401_0301_0201_0101);
    repeat (10) step();
    checkVal("t2 out_valid held", outValid, 1'b1);
    checkVal("t2 out_vec held", outVec, 128'h0801_0701_0601_0501_0401_0301_0201_0101);
    checkVal("t2 in_ready", inReady, 1'b0);
`ifdef TANH_DISPATCH_PERF_EN
    checkVal("t2 stall_count", stallCount, 32'd10);
`endif
    outReady = 1'b1;
    step();
    checkVal("t2 out_valid drop", outValid, 1'b0);
`ifdef TANH_DISPATCH_PERF_EN
    checkVal("t2 vec_count", vecCount, 32'd1);
`endif

    // back-to-back vectors, second acceptance 15 cycles after the first
    inVec   = 128'h00F0_00E0_00D0_00C0_00B0_00A0_0090_0080;
    inValid = 1'b1;
    step();
    inVec = 128'h8000_7FFF_0000_FF00_FFF9_1234_8001_FFFF;
    lat = 1;
    while (inReady !== 1'b1 && lat < 40) begin
      step();
      lat++;
    end
    checkVal("t3 accept spacing", lat, 15);
    step();
    inValid = 1'b0;
    waitValid("t3 vecC valid");
    checkVal("t3 vecC", outVec, 128'h8001_8000_0001_FF01_FFFA_1235_8002_0000);
    waitIdle("t3 idle");

    // in_valid pulse with another vector during ISSUE is ignored
    inVec   = 128'h0007_0006_0005_0004_0003_0002_0001_0000;
    inValid = 1'b1;
    step();
    inValid = 1'b0;
    repeat (2) step();
    inVec   = 128'hAAAA_BBBB_CCCC_DDDD_EEEE_1111_2222_3333;
    inValid = 1'b1;
    step();
    inValid = 1'b0;
    waitValid("t5 valid");
    checkVal("t5 vecD only", outVec, 128'h0008_0007_0006_0005_0004_0003_0002_0001);
    waitIdle("t5 idle");

    // reset in DRAIN after three captures, then a clean vector
    inVec   = 128'h5555_5555_5555_5555_5555_5555_5555_5555;
    inValid = 1'b1;
    step();
    inValid = 1'b0;
    repeat (8) step();
    reset = 1'b1;
    step();
    checkVal("t4 busy", busy, 1'b0);
    checkVal("t4 in_ready", inReady, 1'b1);
    checkVal("t4 out_valid", outValid, 1'b0);
    reset   = 1'b0;
    inVec   = 128'h7F00_0100_FE00_0200_FD00_0300_FC00_0400;
    inValid = 1'b1;
    step();
    inValid = 1'b0;
    waitValid("t4 valid");
    checkVal("t4 vecG", outVec, 128'h7F01_0101_FE01_0201_FD01_0301_FC01_0401);
    waitIdle("t4 idle");

    // minimum build: VEC_LEN=2, PIPE_LAT=1
    sInVec   = 32'h0300_FD00;
    sInValid = 1'b1;
    checkVal("t6 idle act", sActOut, 16'h0000);
    step();
    sInValid = 1'b0;
    checkVal("t6 c1 act", sActOut, 16'hFD00);
    step();
    checkVal("t6 c2 act", sActOut, 16'h0300);
    step();
    checkVal("t6 c3 act", sActOut, 16'h0000);
    checkVal("t6 c3 busy", sBusy, 1'b1);
    checkVal("t6 c3 out_valid", sOutValid, 1'b0);
    step();
    checkVal("t6 c4 out_valid", sOutValid, 1'b1);
    checkVal("t6 c4 out_vec", sOutVec, 32'h0301_FD01);
    checkVal("t6 c4 act", sActOut, 16'h0000);
    checkVal("t6 c4 in_ready", sInReady, 1'b0);
    sOutReady = 1'b1;
    step();
    checkVal("t6 idle out_valid", sOutValid, 1'b0);
    checkVal("t6 idle in_ready", sInReady, 1'b1);
    checkVal("t6 idle act2", sActOut, 16'h0000);
  endtask

  task automatic checkOutput();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
  endtask

  initial begin
    applyStimulus();
    step();
    cmpEn = 1'b0;
    checkOutput();
    $finish;
  end

endmodule
